// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage drives the master side; the memory model drives the slave side.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// LEGv8 instruction-fetch stage: PC, imem req/ack, IF/RF register with a one-entry skid buffer.
// Optional FETCH_PERF_EN adds perf_fetched / perf_redirects counters.
module if_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     br_taken,
  input  logic [63:0]              branchaddr,
  input  logic                     br_reg_sel,
  input  logic [63:0]              br_reg_target,
  if_fetch_stage_if.master         imem,
  output logic                     if_rf_valid,
  output logic [63:0]              if_rf_pc,
  output logic [31:0]              if_rf_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_redirects
`endif
);

  typedef enum logic {
    S_REQ,
    S_DISCARD
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_discard_addr;
  logic        r_buf_full;
  logic [63:0] r_buf_pc;
  logic [31:0] r_buf_instr;
  logic        r_if_rf_valid;
  logic [63:0] r_if_rf_pc;
  logic [31:0] r_if_rf_instr;

  logic        w_req;
  logic        w_fire;
  logic        w_redirect;
  logic        w_accept;
  logic [63:0] w_target;

  // Request stays up until acked; only a full skid buffer (or reset) withdraws it.
  assign w_req      = rst_n & ~r_buf_full;
  assign w_fire     = w_req & imem.imem_ack;
  assign w_redirect = br_taken & r_if_rf_valid & ~stall;
  assign w_target   = br_reg_sel ? br_reg_target : (r_if_rf_pc + branchaddr);
  assign w_accept   = w_fire & (r_state == S_REQ) & ~w_redirect;

  // While discarding, the in-flight address is kept on the bus even though pc already holds the target.
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = (r_state == S_DISCARD) ? r_discard_addr : r_pc;

  assign if_rf_valid = r_if_rf_valid;
  assign if_rf_pc    = r_if_rf_pc;
  assign if_rf_instr = r_if_rf_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_REQ;
      r_pc           <= RESET_PC;
      r_discard_addr <= 64'h0;
      r_buf_full     <= 1'b0;
      r_buf_pc       <= 64'h0;
      r_buf_instr    <= 32'h0;
      r_if_rf_valid  <= 1'b0;
      r_if_rf_pc     <= 64'h0;
      r_if_rf_instr  <= 32'h0;
    end else if (w_redirect) begin
      r_pc          <= w_target;
      r_buf_full    <= 1'b0;
      r_if_rf_valid <= 1'b0;
      r_if_rf_pc    <= 64'h0;
      r_if_rf_instr <= 32'h0;
      if (w_req && !imem.imem_ack) begin
        r_state <= S_DISCARD;
        if (r_state == S_REQ) begin
          r_discard_addr <= r_pc;
        end
      end else begin
        r_state <= S_REQ;
      end
    end else begin
      if ((r_state == S_DISCARD) && w_fire) begin
        r_state <= S_REQ;
      end

      if (w_accept) begin
        r_pc <= r_pc + 64'd4;
        if (stall) begin
          r_buf_full  <= 1'b1;
          r_buf_pc    <= r_pc;
          r_buf_instr <= imem.imem_rdata;
        end
      end

      // A buffered word always drains before any newly acked word can reach IF/RF.
      if (!stall) begin
        if (r_buf_full) begin
          r_buf_full    <= 1'b0;
          r_if_rf_valid <= 1'b1;
          r_if_rf_pc    <= r_buf_pc;
          r_if_rf_instr <= r_buf_instr;
        end else if (w_accept) begin
          r_if_rf_valid <= 1'b1;
          r_if_rf_pc    <= r_pc;
          r_if_rf_instr <= imem.imem_rdata;
        end else begin
          r_if_rf_valid <= 1'b0;
          r_if_rf_pc    <= 64'h0;
          r_if_rf_instr <= 32'h0;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic w_load_valid;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_redirects;

  assign w_load_valid   = ~stall & ~w_redirect & (r_buf_full | w_accept);
  assign perf_fetched   = r_perf_fetched;
  assign perf_redirects = r_perf_redirects;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched   <= 32'h0;
      r_perf_redirects <= 32'h0;
    end else begin
      if (w_load_valid) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_redirect) begin
        r_perf_redirects <= r_perf_redirects + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected IF/RF words go into a scoreboard queue,
// a negedge monitor pops and compares every newly loaded valid IF/RF entry.
module tb_if_fetch_stage;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } expEntry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        brTaken;
  logic [63:0] branchAddr;
  logic        brRegSel;
  logic [63:0] brRegTarget;
  logic        ackOn;
  logic        ifRfValid;
  logic [63:0] ifRfPc;
  logic [31:0] ifRfInstr;
  logic        stallSeen = 1'b1;
`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched;
  logic [31:0] perfRedirects;
`endif

  int totalChecks = 0;
  int badChecks   = 0;
  expEntry_t expQ[$];

  if_fetch_stage_if imemBus();

  function automatic logic [31:0] memWord(input logic [63:0] addr);
    logic [31:0] low;
    low = addr[31:0];
    return low ^ 32'hD503_0000;
  endfunction

  assign imemBus.imem_ack   = ackOn;
  assign imemBus.imem_rdata = memWord(imemBus.imem_addr);

  if_fetch_stage #(.RESET_PC(64'h100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .br_taken      (brTaken),
    .branchaddr    (branchAddr),
    .br_reg_sel    (brRegSel),
    .br_reg_target (brRegTarget),
    .imem          (imemBus),
    .if_rf_valid   (ifRfValid),
    .if_rf_pc      (ifRfPc),
    .if_rf_instr   (ifRfInstr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perfFetched),
    .perf_redirects(perfRedirects)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) stallSeen <= stall;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic stallV, input logic brV, input logic selV,
                               input logic [63:0] offV, input logic [63:0] tgtV, input logic ackV);
    stall       = stallV;
    brTaken     = brV;
    brRegSel    = selV;
    branchAddr  = offV;
    brRegTarget = tgtV;
    ackOn       = ackV;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWord(input logic [63:0] pc);
    expEntry_t e;
    e.pc    = pc;
    e.instr = memWord(pc);
    expQ.push_back(e);
  endtask

  // Only entries loaded on a non-stalled edge are new; held entries are not re-checked.
  always @(negedge clk) begin
    if (rst_n && ifRfValid && !stallSeen) begin
      if (expQ.size() == 0) begin
        totalChecks++;
        badChecks++;
        $display("[TB] FAIL sb_unexpected actual_pc=%h required=none", ifRfPc);
      end else begin
        expEntry_t e;
        e = expQ.pop_front();
        checkOutput("sb_pc", ifRfPc, e.pc);
        checkOutput("sb_instr", {32'h0, ifRfInstr}, {32'h0, e.instr});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    step();
    step();
    checkOutput("rst_req", {63'h0, imemBus.imem_req}, 64'h0);
    checkOutput("rst_valid", {63'h0, ifRfValid}, 64'h0);
    checkOutput("rst_pc", ifRfPc, 64'h0);
    checkOutput("rst_instr", {32'h0, ifRfInstr}, 64'h0);
    checkOutput("rst_addr", imemBus.imem_addr, 64'h100);

    // Sequential fetch from RESET_PC with single-cycle ack
    rst_n = 1'b1;
    ackOn = 1'b1;
    #1;
    checkOutput("seq_req", {63'h0, imemBus.imem_req}, 64'h1);
    checkOutput("seq_addr0", imemBus.imem_addr, 64'h100);
    expectWord(64'h100);
    expectWord(64'h104);
    expectWord(64'h108);
    step();
    checkOutput("seq_addr1", imemBus.imem_addr, 64'h104);
    step();
    checkOutput("seq_addr2", imemBus.imem_addr, 64'h108);
    step();

    // BR to 0x4000, PC-relative offset ignored
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h40, 64'h4000, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h40, 64'h4000, 1'b1);
    checkOutput("br_addr", imemBus.imem_addr, 64'h4000);
    checkOutput("br_bubble", {63'h0, ifRfValid}, 64'h0);
    expectWord(64'h4000);
    step();

    // BR to 0x200 to set up the PC-relative case
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h0, 64'h200, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
    expectWord(64'h200);
    step();

    // PC-relative: 0x200 + (-8) = 0x1F8, register target ignored
    applyStimulus(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h9999, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
    checkOutput("rel_addr", imemBus.imem_addr, 64'h1F8);
    checkOutput("rel_bubble", {63'h0, ifRfValid}, 64'h0);
    expectWord(64'h1F8);
    step();
    checkOutput("rel_valid", {63'h0, ifRfValid}, 64'h1);
    checkOutput("rel_pc", ifRfPc, 64'h1F8);

    // 3-cycle stall with br_taken on the first: branch ignored, one word buffered
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h0, 64'h8000, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
    checkOutput("stall_addr", imemBus.imem_addr, 64'h200);
    checkOutput("stall_req0", {63'h0, imemBus.imem_req}, 64'h0);
    step();
    checkOutput("stall_req1", {63'h0, imemBus.imem_req}, 64'h0);
    checkOutput("stall_hold", ifRfPc, 64'h1F8);
    step();
    checkOutput("stall_req2", {63'h0, imemBus.imem_req}, 64'h0);
    checkOutput("stall_addr2", imemBus.imem_addr, 64'h200);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
    expectWord(64'h1FC);
    step();
    checkOutput("resume_req", {63'h0, imemBus.imem_req}, 64'h1);
    checkOutput("resume_addr", imemBus.imem_addr, 64'h200);
    expectWord(64'h200);
    step();

    // br_taken while IF/RF holds a bubble
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    step();
    checkOutput("idle_bubble", {63'h0, ifRfValid}, 64'h0);
`ifdef FETCH_PERF_EN
    checkOutput("perf_redir_mid", {32'h0, perfRedirects}, 64'd3);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h0, 64'h8000, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    checkOutput("nobr_addr", imemBus.imem_addr, 64'h204);
    checkOutput("nobr_req", {63'h0, imemBus.imem_req}, 64'h1);
`ifdef FETCH_PERF_EN
    checkOutput("perf_redir_ign", {32'h0, perfRedirects}, 64'd3);
`endif

    // Redirect to 0x204+0x100 while the 0x208 request waits for ack
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
    expectWord(64'h204);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h100, 64'h0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    checkOutput("disc_addr0", imemBus.imem_addr, 64'h208);
    checkOutput("disc_req", {63'h0, imemBus.imem_req}, 64'h1);
    checkOutput("disc_bubble", {63'h0, ifRfValid}, 64'h0);
    step();
    checkOutput("disc_addr1", imemBus.imem_addr, 64'h208);
    ackOn = 1'b1;
    step();
    checkOutput("disc_target", imemBus.imem_addr, 64'h304);
    checkOutput("disc_dropped", {63'h0, ifRfValid}, 64'h0);
    expectWord(64'h304);
    expectWord(64'h308);
    step();
    step();
    ackOn = 1'b0;
    step();
    step();
    checkOutput("sb_drained", 64'(expQ.size()), 64'h0);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetched", {32'h0, perfFetched}, 64'd11);
    checkOutput("perf_redirects", {32'h0, perfRedirects}, 64'd4);
`endif

    // Reset asserted mid-request abandons it immediately
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", {63'h0, imemBus.imem_req}, 64'h0);
    checkOutput("midrst_addr", imemBus.imem_addr, 64'h100);
    checkOutput("midrst_valid", {63'h0, ifRfValid}, 64'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
